// File: rtl/image_memory.sv
// image_memory: 28x28 store of signed 32-bit pixel words for the MNIST
// drawing front end. One synchronous write port (drawing grid cursor) and
// one registered read port (VGA / inference), both addressed linearly as
// row*GRID_SIZE + col. Out-of-range addresses never touch storage and read
// back as zero. A same-address read and write in one cycle returns the new
// word (write-through).
module image_memory #(
  parameter int GRID_SIZE  = 28,
  parameter int DEPTH      = GRID_SIZE * GRID_SIZE,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        write_addr,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         write_enable,
  input  logic [ADDR_WIDTH-1:0]        read_addr,
  output logic signed [DATA_WIDTH-1:0] data_out
);

  // Index width just wide enough to select any stored word.
  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH expressed in the address width so range checks compare like widths.
  localparam logic [ADDR_WIDTH-1:0] DEPTH_ADDR = ADDR_WIDTH'(DEPTH);

  // Storage and output register power up cleared even without a reset pulse.
  logic signed [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic signed [DATA_WIDTH-1:0] data_q      = '0;

  logic                 write_valid;
  logic                 read_valid;
  logic                 write_through;
  logic [IDX_WIDTH-1:0] write_idx;
  logic [IDX_WIDTH-1:0] read_idx;

  // Address decode: range checks, truncated array indices, and detection of
  // a same-address read-during-write.
  always_comb begin
    write_valid   = write_enable && (write_addr < DEPTH_ADDR);
    read_valid    = (read_addr < DEPTH_ADDR);
    write_idx     = write_addr[IDX_WIDTH-1:0];
    read_idx      = read_addr[IDX_WIDTH-1:0];
    write_through = write_valid && (write_addr == read_addr);
  end

  // Pixel storage: reset wipes every word in one cycle and beats any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the whole array is cleared in a single reset edge, so this
      // storage is a register array rather than an inferred block RAM,
      // which could not zero all of its words at once.
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking assignment keeps every state update in this
        // edge based on pre-edge values, matching the read register below.
        mem[i] <= '0;
      end
    end else if (write_valid) begin
      mem[write_idx] <= data_in;
    end
  end

  // Registered read port with write-through for a same-address write.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (write_through) begin
      data_q <= data_in;
    end else if (read_valid) begin
      data_q <= mem[read_idx];
    end else begin
      data_q <= '0;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_image_memory.sv
// tb_image_memory: directed scenarios plus randomized traffic for
// image_memory, checked every cycle against a behavioural array model.
module tb_image_memory;

  localparam int DEPTH = 784;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [15:0]        write_addr = '0;
  logic signed [31:0] data_in = '0;
  logic               write_enable = 1'b0;
  logic [15:0]        read_addr = '0;
  logic signed [31:0] data_out;

  int errors = 0;
  int checks = 0;

  // Reference model: plain array of words plus the expected output value.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_out;

  image_memory dut (
    .clk          (clk),
    .reset        (reset),
    .write_addr   (write_addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .read_addr    (read_addr),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, advance the model at the
  // rising edge, then compare data_out shortly after.
  task automatic cycle(input logic r, input logic we, input int wa,
                       input logic [31:0] din, input int ra, input string tag);
    @(negedge clk);
    reset        = r;
    write_enable = we;
    write_addr   = wa[15:0];
    data_in      = din;
    read_addr    = ra[15:0];
    @(posedge clk);
    if (r) begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      exp_out = '0;
    end else begin
      exp_out = (ra < DEPTH) ? ref_mem[ra] : 32'h0;
      if (we && wa < DEPTH) begin
        if (wa == ra) exp_out = din;
        ref_mem[wa] = din;
      end
    end
    #1;
    check(tag, data_out, exp_out);
  endtask

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = '0;
    exp_out = '0;

    #1;
    check("powerup_data_out", data_out, 32'h0);

    // 1: arbitrary writes, one reset cycle, then reads come back zero.
    cycle(0, 1, 0,   32'hdead_beef, 5, "t1_w0");
    cycle(0, 1, 391, 32'h1111_2222, 5, "t1_w391");
    cycle(0, 1, 783, 32'hffff_fff0, 0, "t1_w783");
    cycle(1, 1, 0,   32'h5555_5555, 0, "t1_reset");
    check("t1_reset_out", data_out, 32'h0);
    cycle(0, 0, 0, 0, 0,   "t1_r0");   check("t1_r0_zero", data_out, 32'h0);
    cycle(0, 0, 0, 0, 391, "t1_r391"); check("t1_r391_zero", data_out, 32'h0);
    cycle(0, 0, 0, 0, 783, "t1_r783"); check("t1_r783_zero", data_out, 32'h0);

    // 2: extreme values round-trip.
    cycle(0, 1, 29,  32'sd1,         0, "t2_w29");
    cycle(0, 1, 783, 32'sh8000_0000, 0, "t2_w783");
    cycle(0, 0, 0, 0, 29,  "t2_r29");  check("t2_r29_val", data_out, 32'd1);
    cycle(0, 0, 0, 0, 783, "t2_r783"); check("t2_r783_val", data_out, 32'h8000_0000);

    // 3: write_enable low leaves the word alone.
    cycle(0, 1, 100, 32'd5, 0, "t3_w100");
    cycle(0, 0, 100, 32'd9, 0, "t3_we0");
    cycle(0, 0, 0, 0, 100, "t3_r100"); check("t3_r100_val", data_out, 32'd5);

    // 4: write-through on same address, old contents on a neighbour.
    cycle(0, 1, 50, 32'd7, 50, "t4_wt");   check("t4_wt_val", data_out, 32'd7);
    cycle(0, 1, 50, 32'd7, 51, "t4_diff"); check("t4_diff_val", data_out, 32'h0);

    // 5: out-of-range writes are dropped, out-of-range reads give zero.
    cycle(0, 1, 784,   32'h1234, 0,   "t5_w784");
    cycle(0, 1, 65535, 32'h1234, 16,  "t5_w65535");
    cycle(0, 1, 784,   32'h1234, 784, "t5_r784_wt"); check("t5_r784_zero", data_out, 32'h0);
    cycle(0, 0, 0, 0, 0,   "t5_r0");   check("t5_r0_zero", data_out, 32'h0);
    cycle(0, 0, 0, 0, 16,  "t5_r16");  check("t5_r16_zero", data_out, 32'h0);

    // 6: back-to-back stream of addr+1 with reset on write #400.
    for (int k = 0; k < DEPTH; k++)
      cycle(k == 400, 1, k, 32'(k + 1), (k * 7) % 800, "t6_stream");
    cycle(0, 0, 0, 0, 0,   "t6_r0");   check("t6_r0_zero", data_out, 32'h0);
    cycle(0, 0, 0, 0, 398, "t6_r398"); check("t6_r398_zero", data_out, 32'h0);
    cycle(0, 0, 0, 0, 400, "t6_r400"); check("t6_r400_dropped", data_out, 32'h0);
    cycle(0, 0, 0, 0, 401, "t6_r401"); check("t6_r401_val", data_out, 32'd402);
    cycle(0, 0, 0, 0, 783, "t6_r783"); check("t6_r783_val", data_out, 32'd784);

    // Randomized traffic with occasional resets, collisions and bad addresses.
    for (int n = 0; n < 2000; n++) begin
      int wa, ra, sel;
      logic r, we;
      sel = $urandom_range(0, 9);
      wa  = (sel == 0) ? $urandom_range(784, 65535) :
            (sel == 1) ? 784 : $urandom_range(0, 783);
      sel = $urandom_range(0, 9);
      ra  = (sel < 3) ? wa : (sel == 3) ? $urandom_range(784, 65535)
                                        : $urandom_range(0, 783);
      r   = ($urandom_range(0, 127) == 0);
      we  = ($urandom_range(0, 3) != 0);
      cycle(r, we, wa, $urandom, ra, "rand");
    end

    // Final sweep: every word must match the model.
    for (int a = 0; a < DEPTH; a++)
      cycle(0, 0, 0, 0, a, "sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
